// File: rtl/hazard_controller.sv
// hazard_controller: forwarding, load-use stall, branch flush and memory wait-state freeze
// for a 5-stage RISC-V pipeline, with saturating stall/flush cycle counters.
module hazard_controller #(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegwriteM,
  input  logic             RegwriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(WAIT_TIMEOUT);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic lw_stall, mem_freeze, timeout, flush_evt;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (rs != 5'd0 && rs == RdM && RegwriteM) ? 2'b10 :
           (rs != 5'd0 && rs == RdW && RegwriteW) ? 2'b01 : 2'b00;
  endfunction
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (StallF && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    lw_stall   = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    timeout    = state == MEM_WAIT && !MemReadyM && wait_cnt == TMO;
    mem_freeze = (state == RUN && MemReqM && !MemReadyM) ||
                 (state == MEM_WAIT && !MemReadyM && !timeout);
    if (state == RUN && MemReqM && !MemReadyM) begin
      state_n    = MEM_WAIT;
      wait_cnt_n = WW'(1);
    end else if (state == MEM_WAIT) begin
      state_n    = (MemReadyM || timeout) ? RUN : MEM_WAIT;
      wait_cnt_n = (MemReadyM || timeout) ? '0 : wait_cnt + WW'(1);
    end
    ForwardAE = reset ? 2'b00 : fwd(Rs1E);
    ForwardBE = reset ? 2'b00 : fwd(Rs2E);
    StallF    = !reset && (lw_stall || mem_freeze);
    StallD    = !reset && (lw_stall || mem_freeze);
    StallE    = !reset && mem_freeze;
    StallM    = !reset && mem_freeze;
    FlushW    = reset || mem_freeze;
    FlushD    = reset || (PCSrcE && !mem_freeze);
    FlushE    = reset || ((lw_stall || PCSrcE) && !mem_freeze);
    flush_evt = !reset && PCSrcE && !mem_freeze;
    mem_error = !reset && timeout;
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors with hand-computed expectations for hazard_controller.
module tb_hazard_controller;
  logic clock = 0, reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegwriteM, RegwriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_error;
  logic [3:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  hazard_controller #(.WAIT_TIMEOUT(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_error(mem_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegwriteM, RegwriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    idle();
    reset = 1;
    MemReqM = 1;
    step();
    step();
    check("rst_stall", {StallF, StallD, StallE, StallM}, 4'b0000);
    check("rst_flush", {FlushD, FlushE, FlushW}, 3'b111);
    check("rst_fwd", {ForwardAE, ForwardBE}, 4'b0000);
    check("rst_cnt", {stall_cnt, flush_cnt}, 8'h00);
    check("rst_err", mem_error, 0);
    reset = 0;
    idle();
    #1;
    check("idle_flush", {FlushD, FlushE, FlushW, StallF}, 4'b0000);
    Rs1E = 5; RdM = 5; RegwriteM = 1; #1;
    check("fwdA_m", ForwardAE, 2'b10);
    Rs1E = 0; RdM = 0; #1;
    check("fwdA_x0", ForwardAE, 2'b00);
    RdM = 7; RdW = 7; RegwriteW = 1; Rs2E = 7; #1;
    check("fwdB_m_prio", ForwardBE, 2'b10);
    RegwriteM = 0; #1;
    check("fwdB_w", ForwardBE, 2'b01);
    RegwriteW = 0; #1;
    check("fwdB_none", ForwardBE, 2'b00);
    idle();
    LoadE = 1; RdE = 3; Rs1D = 3; #1;
    check("lw_stall", {StallF, StallD, StallE, StallM, FlushD, FlushE}, 6'b110001);
    step();
    LoadE = 0; #1;
    check("lw_release", {StallF, FlushE}, 2'b00);
    check("lw_cnt", stall_cnt, 1);
    RdE = 0; Rs1D = 0; LoadE = 1; #1;
    check("lw_x0", StallF, 0);
    idle();
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_freeze", {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
      step();
    end
    MemReadyM = 1; #1;
    check("mw_ready", {StallF, StallM, FlushW}, 3'b000);
    step();
    idle(); #1;
    check("mw_run", StallF, 0);
    check("mw_cnt", stall_cnt, 4);
    MemReqM = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_freeze", {StallF, mem_error}, 2'b10);
      step();
    end
    check("to_release", {StallF, StallM, mem_error}, 3'b001);
    step();
    MemReqM = 0; #1;
    check("to_pulse_end", {mem_error, StallF}, 2'b00);
    check("to_cnt", stall_cnt, 8);
    MemReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("br_frozen", {FlushD, FlushE, StallF}, 3'b001);
      step();
    end
    MemReadyM = 1; #1;
    check("br_release", {FlushD, FlushE, StallF}, 3'b110);
    step();
    idle(); #1;
    check("br_fcnt", flush_cnt, 1);
    check("br_scnt", stall_cnt, 10);
    LoadE = 1; RdE = 3; Rs2D = 3; PCSrcE = 1; #1;
    check("lw_br", {FlushD, FlushE, StallF, StallD}, 4'b1111);
    step();
    check("lw_br_cnt", {stall_cnt, flush_cnt}, {4'd11, 4'd2});
    PCSrcE = 0;
    for (int i = 0; i < 6; i++) step();
    check("sat_stall", stall_cnt, 15);
    idle();
    MemReqM = 1;
    step();
    reset = 1; #1;
    check("rst_mw_out", {StallF, mem_error, FlushW}, 3'b001);
    step();
    reset = 0; MemReqM = 0; #1;
    check("rst_mw_run", {StallF, mem_error}, 2'b00);
    check("rst_mw_cnt", {stall_cnt, flush_cnt}, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
